// File: rtl/hex_glyph_sequencer_pkg.sv
// Shared glyph geometry and sequencer state encoding for the glyph renderers.
package hex_glyph_sequencer_pkg;

  localparam int unsigned GLYPH_W = 5;
  localparam int unsigned GLYPH_H = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/hex_glyph_sequencer_col_shifter.sv
// Holds one glyph row and walks its columns plus the trailing gap columns,
// producing the current pixel and an end-of-digit flag.
module glyph_col_shifter
  import hex_glyph_sequencer_pkg::*;
#(
  parameter int unsigned GAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic               gap_en,
  input  logic [GLYPH_W-1:0] bits,
  output logic               pix_data,
  output logic               end_of_digit
);

  logic [GLYPH_W-1:0] glyph_q, glyph_d;
  logic [2:0]         col_q, col_d;

  // Next glyph/column: load restarts at column 0, accept steps one column.
  always_comb begin
    glyph_d = glyph_q;
    col_d   = col_q;
    if (load) begin
      glyph_d = bits;
      col_d   = '0;
    end else if (advance) begin
      col_d = col_q + 3'd1;
    end
  end

  // Glyph row and column registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      glyph_q <= '0;
      col_q   <= '0;
    end else begin
      glyph_q <= glyph_d;
      col_q   <= col_d;
    end
  end

  // Glyph columns come from the register, gap columns are blank.
  always_comb begin
    pix_data = 1'b0;
    if (col_q < 3'(GLYPH_W)) begin
      pix_data = glyph_q[col_q];
    end
  end

  // Last column of this digit: glyph edge, or end of the gap when one follows.
  always_comb begin
    end_of_digit = (col_q == 3'(GLYPH_W - 1));
    if (gap_en) begin
      end_of_digit = (col_q == 3'(GLYPH_W - 1 + GAP));
    end
  end

endmodule

// File: rtl/hex_glyph_sequencer.sv
// Renders an NDIGITS hex value as a row-major 5-row pixel stream by stepping
// an external 5x5 glyph ROM row by row, digit by digit (MSD first).
module hex_glyph_sequencer
  import hex_glyph_sequencer_pkg::*;
#(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned GAP     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   value,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             rom_digit,
  output logic [2:0]             rom_yoff,
  input  logic [4:0]             rom_bits,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_data,
  output logic [7:0]             pix_x,
  output logic [2:0]             pix_y,
  output logic                   pix_last
);

  state_e               state_q, state_d;
  logic [4*NDIGITS-1:0] value_q, value_d;
  logic [2:0]           row_q, row_d;
  logic [2:0]           digit_q, digit_d;
  logic [7:0]           x_q, x_d;

  logic [3:0] nibble;
  logic       last_digit;
  logic       last_row;
  logic       sh_load;
  logic       sh_advance;
  logic       sh_pix;
  logic       sh_end;

  assign last_digit = (digit_q == 3'(NDIGITS - 1));
  assign last_row   = (row_q == 3'(GLYPH_H - 1));

  // Select the latched nibble for the current digit, digit 0 being the MSD.
  always_comb begin
    nibble = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (digit_q == 3'(i)) begin
        nibble = value_q[4*(NDIGITS-1-i) +: 4];
      end
    end
  end

  glyph_col_shifter #(
    .GAP (GAP)
  ) u_col_shifter (
    .clk          (clk),
    .rst          (rst),
    .load         (sh_load),
    .advance      (sh_advance),
    .gap_en       (!last_digit),
    .bits         (rom_bits),
    .pix_data     (sh_pix),
    .end_of_digit (sh_end)
  );

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    row_d      = row_q;
    digit_d    = digit_q;
    x_d        = x_q;
    busy       = 1'b0;
    done       = 1'b0;
    rom_digit  = '0;
    rom_yoff   = '0;
    pix_valid  = 1'b0;
    pix_data   = 1'b0;
    pix_x      = '0;
    pix_y      = '0;
    pix_last   = 1'b0;
    sh_load    = 1'b0;
    sh_advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          value_d = value;
          row_d   = '0;
          digit_d = '0;
          x_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy      = 1'b1;
        rom_digit = nibble;
        rom_yoff  = row_q;
        sh_load   = 1'b1;
        state_d   = ST_EMIT;
      end
      ST_EMIT: begin
        busy      = 1'b1;
        rom_digit = nibble;
        rom_yoff  = row_q;
        pix_valid = 1'b1;
        pix_data  = sh_pix;
        pix_x     = x_q;
        pix_y     = row_q;
        pix_last  = last_digit && last_row && sh_end;
        if (pix_ready) begin
          x_d        = x_q + 8'd1;
          sh_advance = 1'b1;
          if (sh_end) begin
            if (!last_digit) begin
              digit_d = digit_q + 3'd1;
              state_d = ST_LOAD;
            end else if (!last_row) begin
              row_d   = row_q + 3'd1;
              digit_d = '0;
              x_d     = '0;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched value and position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      row_q   <= '0;
      digit_q <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      row_q   <= row_d;
      digit_q <= digit_d;
      x_q     <= x_d;
    end
  end

endmodule
